axis_vec_tx: RTL and testbench
==============================

Name: axis_vec_tx

Overview:
- AXI-Stream transmitter that feeds one operand channel (image, kernel or bias) of the convolution datapath.
- A host/testbench side fills an internal FIFO, then issues start with a vector length.
- The block emits exactly that many beats on the master stream and flags the final beat with TLAST.
- One instance is placed per operand channel.

Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 16, FIFO entries; must be a power of 2, ≥2.
- LEN_W, 8, width of the vector-length input.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  DATA_W  word to push.
- wr_full  out  1  FIFO full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky: a write was dropped.
- start  in  1  begin a vector; sampled only in IDLE.
- len  in  LEN_W  beats in the vector; latched with start.
- busy  out  1  high in SEND.
- done  out  1  one-cycle pulse after the last beat is accepted.
- m_TDATA  out  DATA_W  stream data (registered).
- m_TVALID  out  1  stream valid (registered).
- m_TLAST  out  1  last beat of vector (registered).
- m_TREADY  in  1  downstream ready.

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. All outputs go to 0, state goes to IDLE, FIFO is emptied, ovf is cleared, remaining count is 0.
- FSM states: IDLE, SEND, DONE.
  - IDLE→SEND when start=1. Latch rem=len.
  - If len=0, go IDLE→DONE instead; no beats are sent.
  - start in SEND or DONE is ignored.
  - SEND→DONE on the cycle a beat with m_TLAST=1 is accepted (m_TVALID && m_TREADY).
  - DONE→IDLE unconditionally. done=1 only in DONE.
- Output register, in SEND only:
  - Load condition: (!m_TVALID || m_TREADY) && FIFO non-empty && rem>0.
  - On load: m_TDATA←FIFO head, pop, m_TVALID←1, m_TLAST←(rem==1), rem←rem-1.
  - Otherwise, if m_TREADY: m_TVALID←0, m_TLAST←0.
  - While m_TVALID=1 && m_TREADY=0, m_TDATA and m_TLAST are held stable. This is the AXI-S rule.
- Latency:
  - start at cycle t gives SEND at t+1.
  - First m_TVALID at t+2 if FIFO is non-empty.
  - Back-to-back beats at 1/cycle while m_TREADY=1 and data is available.
- FIFO:
  - Show-ahead, no write-to-read bypass. A word written into an empty FIFO is eligible the following cycle.
  - Write and pop in the same cycle when full: the write is accepted and level is unchanged.
  - Write while full without a pop: the word is dropped and ovf←1. ovf stays set until reset.
  - Pointers wrap modulo DEPTH. level = wr_cnt − rd_cnt using an extra MSB.
- Underrun: FIFO empty in SEND means m_TVALID deasserts after the current beat is accepted, and the FSM waits in SEND.
- Reset mid-vector: abort immediately. m_TVALID drops asynchronously and no TLAST is emitted.
- FIFO contents persist across vectors. Leftover words feed the next vector.

Optional Feature:
- Macro: AXIS_VEC_TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [15:0].
  - Increments each cycle in SEND with rem>0, FIFO empty and (!m_TVALID || m_TREADY).
  - Saturates at 16'hFFFF.
  - Cleared by reset and on the IDLE→SEND transition.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package axis_tx_pkg holds:
  - typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;
  - localparam helpers for pointer width.
- One sub-module, sync_fifo (DATA_W, DEPTH): wr/rd enables, show-ahead rdata, full, empty, level.
- FSM, rem counter and output register live in axis_vec_tx.

Test Plan:
- Basic vector: write 0x11,0x22,0x33; start, len=3, m_TREADY=1 → beats 0x11,0x22,0x33 on consecutive cycles, m_TLAST only on 0x33, done pulse one cycle later, level=0.
- Backpressure: len=2, data 0xA0,0xA1, m_TREADY low for 4 cycles on first beat → m_TDATA=0xA0 held stable with m_TVALID=1; then 0xA1 with TLAST; done once.
- Underrun: start len=4 with 1 word queued, then write 3 more after 5 idle cycles → 4 beats total, gap in m_TVALID, TLAST on 4th. With the macro defined, underrun_cnt≥4.
- Overflow/full: write 17 words with DEPTH=16 → wr_full=1 after 16, ovf=1, level=16. Then write while a pop occurs in the same cycle → accepted, ovf remains 1.
- len=0 and ignored start: start len=0 → done the next cycle, no m_TVALID. A start pulse during SEND changes neither rem nor the beat count.
- Reset mid-vector: len=5, assert reset after 2 beats → m_TVALID=0, busy=0, level=0 immediately. A new vector afterwards operates normally.

Source files
------------

// File: rtl/axis_tx_pkg.sv
// Shared types and sizing helpers for the axis_vec_tx operand transmitter.
// Optional build macro: AXIS_VEC_TX_UNDERRUN_CNT_EN (underrun counter width lives here).
package axis_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_DONE
    } tx_state_t;

    localparam int unsigned UCNT_W = 16;
    localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

    // Address width of a FIFO with the given power-of-two depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. Read data is the current head, no write-to-read
// bypass; a write and a pop in the same cycle are both honoured even when full.
module sync_fifo
    import axis_tx_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    level
);

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_cnt_q;
    logic [PTR_W:0]    rd_cnt_q;
    logic              wr_ok;
    logic              rd_ok;

    // Counters carry an extra MSB so full and empty are distinguishable.
    assign level = wr_cnt_q - rd_cnt_q;
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign rdata = mem_q[rd_cnt_q[PTR_W-1:0]];

    // Storage array write port.
    // NOTE: the data array has no reset; only the pointers define what is valid,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_cnt_q[PTR_W-1:0]] <= wr_data;
        end
    end

    // Write and read pointer advance.
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_ok) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (rd_ok) rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/axis_vec_tx.sv
// AXI-Stream vector transmitter: a FIFO is filled from the host side, then a
// start/len command emits exactly len beats with TLAST on the final one.
// Optional build macro: AXIS_VEC_TX_UNDERRUN_CNT_EN adds underrun_cnt[15:0].
module axis_vec_tx
    import axis_tx_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned LEN_W  = 8,
    localparam int unsigned LVL_W  = ptr_w(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic [LVL_W-1:0]  level,
    output logic              ovf,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m_TDATA,
    output logic              m_TVALID,
    output logic              m_TLAST,
    input  logic              m_TREADY
`ifdef AXIS_VEC_TX_UNDERRUN_CNT_EN
    ,
    output logic [UCNT_W-1:0] underrun_cnt
`endif
);

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;
    logic              in_send;
    logic              slot_free;
    logic              load;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (load),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // The output slot can take a new word when it is empty or being drained.
    assign in_send   = (state_q == TX_SEND);
    assign slot_free = !tvalid_q || m_TREADY;
    assign load      = in_send && slot_free && !fifo_empty && (rem_q != '0);

`ifdef AXIS_VEC_TX_UNDERRUN_CNT_EN
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;

    // Count cycles where the slot could accept a beat but the FIFO is dry.
    always_comb begin
        ucnt_d = ucnt_q;
        if (state_q == TX_IDLE && start && len != '0) begin
            ucnt_d = '0;
        end else if (in_send && rem_q != '0 && fifo_empty && slot_free && ucnt_q != UCNT_MAX) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ucnt_q <= '0;
        else       ucnt_q <= ucnt_d;
    end

    assign underrun_cnt = ucnt_q;
`endif

    // Next-state, remaining count, output slot and overflow flag.
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        ovf_d    = ovf_q;

        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    rem_d   = len;
                    state_d = (len == '0) ? TX_DONE : TX_SEND;
                end
            end
            TX_SEND: begin
                if (tvalid_q && m_TREADY && tlast_q) state_d = TX_DONE;
            end
            TX_DONE: state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase

        if (load) begin
            tdata_d  = fifo_rdata;
            tvalid_d = 1'b1;
            tlast_d  = (rem_q == LEN_W'(1));
            rem_d    = rem_q - LEN_W'(1);
        end else if (m_TREADY) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        // A write to a full FIFO is only lost when no pop frees a slot.
        if (wr_en && fifo_full && !load) ovf_d = 1'b1;
    end

    // State and output registers; reset aborts any vector immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            rem_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = in_send;
    assign done     = (state_q == TX_DONE);
    assign wr_full  = fifo_full;
    assign ovf      = ovf_q;
    assign m_TDATA  = tdata_q;
    assign m_TVALID = tvalid_q;
    assign m_TLAST  = tlast_q;

endmodule

// File: tb/tb_axis_vec_tx.sv
// Self-checking bench for axis_vec_tx: directed scenarios plus randomized
// vectors scored against a queue-based model of the FIFO and the beat stream.
// Optional build macro: AXIS_VEC_TX_UNDERRUN_CNT_EN.
module tb_axis_vec_tx;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic [LVL_W-1:0]  level;
    logic              ovf;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] m_TDATA;
    logic              m_TVALID;
    logic              m_TLAST;
    logic              m_TREADY;
`ifdef AXIS_VEC_TX_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    axis_vec_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_full  (wr_full),
        .level    (level),
        .ovf      (ovf),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .m_TDATA  (m_TDATA),
        .m_TVALID (m_TVALID),
        .m_TLAST  (m_TLAST),
        .m_TREADY (m_TREADY)
`ifdef AXIS_VEC_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    int                n_vec = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] model_q [$];   // words the FIFO should hold, head first
    beat_t             cap_q [$];     // beats accepted on the stream
    int                done_cnt  = 0;
    int                done_base = 0;
    logic              prev_hold;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stream monitor: capture accepted beats, count done pulses, and require
    // data/last to stay put while a beat is stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", m_TVALID, 1);
                check("hold_data", m_TDATA, prev_data);
                check("hold_last", m_TLAST, prev_last);
            end
            if (m_TVALID && m_TREADY) cap_q.push_back('{m_TDATA, m_TLAST});
            if (done) done_cnt <= done_cnt + 1;
            prev_hold <= m_TVALID && !m_TREADY;
            prev_data <= m_TDATA;
            prev_last <= m_TLAST;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word; the model keeps it only if the FIFO has room.
    task automatic push_word(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(d);
    endtask

    task automatic start_vec(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready);
        int cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            if (rnd_ready) m_TREADY = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        check("done_seen", done, 1);
        m_TREADY = 1'b1;
        step();
    endtask

    // Expected stream for a vector of n: the next n model words, TLAST on the last.
    task automatic check_vector(input string tag, input int n);
        check({tag, "_beats"}, cap_q.size(), n);
        for (int i = 0; i < n && cap_q.size() > 0; i++) begin
            beat_t b;
            b = cap_q.pop_front();
            check({tag, "_data"}, b.data, model_q.pop_front());
            check({tag, "_last"}, b.last, (i == n - 1));
        end
        cap_q.delete();
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        done_base = done_cnt;
        check({tag, "_level"}, level, model_q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; len = '0; m_TREADY = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_TVALID, 0);
        check("rst_last", m_TLAST, 0);
        check("rst_data", m_TDATA, 0);
        check("rst_level", level, 0);
        check("rst_full", wr_full, 0);
        check("rst_ovf", ovf, 0);
`ifdef AXIS_VEC_TX_UNDERRUN_CNT_EN
        check("rst_ucnt", underrun_cnt, 0);
`endif

        // Basic vector with exact cycle timing
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        start_vec(3);
        check("basic_busy", busy, 1);
        check("basic_nvalid", m_TVALID, 0);
        step();
        check("basic_v0", m_TVALID, 1); check("basic_d0", m_TDATA, 8'h11); check("basic_l0", m_TLAST, 0);
        step();
        check("basic_v1", m_TVALID, 1); check("basic_d1", m_TDATA, 8'h22); check("basic_l1", m_TLAST, 0);
        step();
        check("basic_v2", m_TVALID, 1); check("basic_d2", m_TDATA, 8'h33); check("basic_l2", m_TLAST, 1);
        step();
        check("basic_done", done, 1); check("basic_valid_off", m_TVALID, 0); check("basic_busy_off", busy, 0);
        step();
        check("basic_done_off", done, 0);
        check_vector("basic", 3);

        // Backpressure on the first beat
        m_TREADY = 1'b0;
        push_word(8'hA0); push_word(8'hA1);
        start_vec(2);
        step();
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", m_TVALID, 1);
            check("bp_data", m_TDATA, 8'hA0);
            check("bp_last", m_TLAST, 0);
            if (i < 3) step();
        end
        m_TREADY = 1'b1;
        wait_done(300, 1'b0);
        check_vector("bp", 2);

        // Underrun: one word queued, rest arrives late
        push_word(8'h51);
        start_vec(4);
        repeat (5) step();
        check("ur_gap_valid", m_TVALID, 0);
        check("ur_gap_busy", busy, 1);
        push_word(8'h52); push_word(8'h53); push_word(8'h54);
        wait_done(300, 1'b0);
`ifdef AXIS_VEC_TX_UNDERRUN_CNT_EN
        check("ur_cnt_ge4", (underrun_cnt >= 16'd4), 1);
`endif
        check_vector("ur", 4);

        // Overflow / full
        for (int i = 0; i < DEPTH; i++) push_word(DATA_W'(8'hC0 + i));
        check("full_full", wr_full, 1);
        check("full_level", level, DEPTH);
        check("full_ovf0", ovf, 0);
        push_word(8'hFF);
        check("ovf_set", ovf, 1);
        check("ovf_level", level, DEPTH);
        check("ovf_full", wr_full, 1);
        start_vec(1);
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        model_q.push_back(8'hEE);
        check("wpop_level", level, DEPTH);
        check("wpop_ovf", ovf, 1);
        wait_done(300, 1'b0);
        check_vector("wpop", 1);
        start_vec(DEPTH);
        wait_done(300, 1'b0);
        check_vector("drain", DEPTH);

        // len=0 then an ignored start during SEND
        push_word(8'h61); push_word(8'h62);
        start_vec(0);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_valid", m_TVALID, 0);
        step();
        check("len0_done_off", done, 0);
        check("len0_beats", cap_q.size(), 0);
        check("len0_done_pulses", done_cnt - done_base, 1);
        done_base = done_cnt;
        check("len0_level", level, 2);
        push_word(8'h63);
        m_TREADY = 1'b0;
        start_vec(3);
        step();
        start = 1'b1; len = 8'd7;
        step();
        start = 1'b0;
        m_TREADY = 1'b1;
        wait_done(300, 1'b0);
        check_vector("ign", 3);

        // Reset mid-vector
        for (int i = 0; i < 5; i++) push_word(DATA_W'(8'h70 + i));
        start_vec(5);
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("rmv_valid", m_TVALID, 0);
        check("rmv_last", m_TLAST, 0);
        check("rmv_busy", busy, 0);
        check("rmv_level", level, 0);
        check("rmv_ovf", ovf, 0);
        check("rmv_beats", cap_q.size(), 2);
        for (int i = 0; i < 2 && cap_q.size() > 0; i++) begin
            beat_t b;
            b = cap_q.pop_front();
            check("rmv_data", b.data, model_q.pop_front());
            check("rmv_last_cap", b.last, 0);
        end
        model_q.delete();
        cap_q.delete();
        step(); step();
        reset = 1'b0;
        step();
        done_base = done_cnt;

        // Randomized vectors with random backpressure; leftovers carry over
        for (int v = 0; v < 20; v++) begin
            int room;
            int n_push;
            int n_len;
            room   = DEPTH - model_q.size();
            n_push = $urandom_range(0, room);
            if (model_q.size() == 0 && n_push == 0) n_push = 1;
            for (int i = 0; i < n_push; i++) push_word(DATA_W'($urandom));
            n_len = $urandom_range(1, model_q.size());
            start_vec(n_len);
            wait_done(400, 1'b1);
            check_vector("rnd", n_len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
